// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory stage and its load/store unit.
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_t;

    // Funct3 access size / signedness encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Writeback result source encodings
    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    // Byte-lane mask of an access, before shifting to its offset
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // True when the byte offset is not a multiple of the access size
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
        logic [2:0] low_bits;
        case (sz)
            2'b00:   low_bits = 3'b000;
            2'b01:   low_bits = 3'b001;
            2'b10:   low_bits = 3'b011;
            default: low_bits = 3'b111;
        endcase
        return |(off & low_bits);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
interface memory_stage_if;
    logic        DMemReq;
    logic        DMemWe;
    logic [63:0] DMemAddr;
    logic [63:0] DMemWData;
    logic [7:0]  DMemBe;
    logic [63:0] DMemRData;
    logic        DMemAck;

    modport master (
        output DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
        input  DMemRData, DMemAck
    );

    modport slave (
        input  DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
        output DMemRData, DMemAck
    );
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane alignment: store data/byte enables and load extract/extend.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] store_data,
    input  logic [63:0] load_raw,
    output logic [63:0] store_wdata,
    output logic [7:0]  store_be,
    output logic [63:0] load_data
);
    logic [63:0] shifted_s;

    // Shift store data into its lanes; bytes past the doubleword fall off the 8-bit mask
    always_comb begin
        store_wdata = store_data << {off, 3'b000};
        if (funct3[2] == 1'b0) begin
            store_be = size_mask(funct3[1:0]) << off;
        end else begin
            store_be = 8'h00;
        end
    end

    // Bring the addressed bytes down to bit 0, then sign- or zero-extend by size
    always_comb begin
        shifted_s = load_raw >> {off, 3'b000};
        case (funct3)
            F3_B:    load_data = {{56{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    load_data = {{48{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    load_data = {{32{shifted_s[31]}}, shifted_s[31:0]};
            F3_D:    load_data = shifted_s;
            F3_BU:   load_data = {56'h0, shifted_s[7:0]};
            F3_HU:   load_data = {48'h0, shifted_s[15:0]};
            F3_WU:   load_data = {32'h0, shifted_s[31:0]};
            default: load_data = 64'h0;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: EX/MEM register, load/store unit with req/ack and
// timeout, MEM/WB register. Define MISALIGN_TRAP_EN to suppress misaligned
// accesses and report them on Misaligned_W.
module memory_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           ALUResult_E,
    input  logic [63:0]           WriteData_E,
    input  logic [63:0]           PCPlus4_E,
    input  logic [4:0]            Rd_E,
    input  logic                  RegWrite_E,
    input  logic                  MemRead_E,
    input  logic                  MemWrite_E,
    input  logic [1:0]            ResultSrc_E,
    input  logic [2:0]            Funct3_E,
    output logic [63:0]           ALUResult_M,
    output logic [4:0]            Rd_M,
    output logic                  RegWrite_M,
    output logic                  Stall_M,
    memory_stage_if.master        dmem,
    output logic [63:0]           Result_W,
    output logic [4:0]            Rd_W,
    output logic                  RegWrite_W,
`ifdef MISALIGN_TRAP_EN
    output logic                  Misaligned_W,
`endif
    output logic                  BusErr_W
);
    logic [63:0]      alu_r, wdata_r, pc4_r;
    logic [4:0]       rd_r;
    logic             regwrite_r, memread_r, memwrite_r;
    logic [1:0]       resultsrc_r;
    logic [2:0]       funct3_r;

    lsu_state_t       state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s, cnt_inc_s;

    logic             mem_op_s, misalign_s, active_s, stall_s, timeout_s;
    logic [2:0]       off_s;
    logic [63:0]      st_wdata_s, ld_data_s, result_s;
    logic [7:0]       st_be_s;

    assign off_s     = alu_r[2:0];
    assign mem_op_s  = memread_r | memwrite_r;
    assign cnt_inc_s = cnt_r + CNT_W'(1);

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = mem_op_s & is_misaligned(funct3_r[1:0], off_s);
`else
    assign misalign_s = 1'b0;
`endif

    mem_align u_align (
        .funct3      (funct3_r),
        .off         (off_s),
        .store_data  (wdata_r),
        .load_raw    (dmem.DMemRData),
        .store_wdata (st_wdata_s),
        .store_be    (st_be_s),
        .load_data   (ld_data_s)
    );

    // EX/MEM register: advances unless the memory access is still outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_r       <= 64'h0;
            wdata_r     <= 64'h0;
            pc4_r       <= 64'h0;
            rd_r        <= 5'd0;
            regwrite_r  <= 1'b0;
            memread_r   <= 1'b0;
            memwrite_r  <= 1'b0;
            resultsrc_r <= 2'b00;
            funct3_r    <= 3'b000;
        end else if (!stall_s) begin
            alu_r       <= ALUResult_E;
            wdata_r     <= WriteData_E;
            pc4_r       <= PCPlus4_E;
            rd_r        <= Rd_E;
            regwrite_r  <= RegWrite_E;
            memread_r   <= MemRead_E;
            memwrite_r  <= MemWrite_E;
            resultsrc_r <= ResultSrc_E;
            funct3_r    <= Funct3_E;
        end
    end

    // LSU state and timeout counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // LSU next state: a memory op in IDLE is already an access in its first cycle
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        active_s     = 1'b0;
        stall_s      = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_op_s && !misalign_s) begin
                    active_s = 1'b1;
                end else begin
                    active_s = 1'b0;
                end
            end
            ACCESS:  active_s = 1'b1;
            default: active_s = 1'b0;
        endcase
        if (active_s) begin
            if (dmem.DMemAck) begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end else if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout_s    = 1'b1;
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end else begin
                stall_s      = 1'b1;
                state_next_s = ACCESS;
                cnt_next_s   = cnt_inc_s;
            end
        end else begin
            state_next_s = IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
        end
    end

    // Writeback result selection
    always_comb begin
        case (resultsrc_r)
            RS_ALU:  result_s = alu_r;
            RS_LOAD: result_s = ld_data_s;
            RS_PC4:  result_s = pc4_r;
            default: result_s = 64'h0;
        endcase
    end

    // MEM/WB register: bubble while stalled, squash the write on timeout or trap
    always_ff @(posedge clk) begin
        if (rst) begin
            Result_W     <= 64'h0;
            Rd_W         <= 5'd0;
            RegWrite_W   <= 1'b0;
            BusErr_W     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            Misaligned_W <= 1'b0;
`endif
        end else if (stall_s) begin
            RegWrite_W   <= 1'b0;
            BusErr_W     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            Misaligned_W <= 1'b0;
`endif
        end else begin
            Result_W     <= result_s;
            Rd_W         <= rd_r;
            RegWrite_W   <= regwrite_r & ~timeout_s & ~misalign_s;
            BusErr_W     <= timeout_s;
`ifdef MISALIGN_TRAP_EN
            Misaligned_W <= misalign_s;
`endif
        end
    end

    assign ALUResult_M    = alu_r;
    assign Rd_M           = rd_r;
    assign RegWrite_M     = regwrite_r;
    assign Stall_M        = stall_s;

    assign dmem.DMemReq   = active_s;
    assign dmem.DMemWe    = active_s & memwrite_r;
    assign dmem.DMemAddr  = active_s ? {alu_r[63:3], 3'b000} : 64'h0;
    assign dmem.DMemWData = active_s ? st_wdata_s : 64'h0;
    assign dmem.DMemBe    = active_s ? st_be_s : 8'h00;
endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: the bench acts as data memory and checks
// every cycle against a transaction-level model of the stage.
module tb_memory_stage;
    localparam int TMO = 64;

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] wd;
        logic [63:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [7:0]  lat;
    } instr_t;

    logic        clk, rst;
    logic [63:0] alu_e, wd_e, pc4_e;
    logic [4:0]  rd_e;
    logic        rw_e, mr_e, mw_e;
    logic [1:0]  rs_e;
    logic [2:0]  f3_e;
    logic [63:0] alu_m, result_w;
    logic [4:0]  rd_m, rd_w;
    logic        rw_m, stall_m, rw_w, buserr_w;
`ifdef MISALIGN_TRAP_EN
    logic        mis_w;
`endif

    memory_stage_if dmem_bus();

    memory_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ALUResult_E (alu_e),
        .WriteData_E (wd_e),
        .PCPlus4_E   (pc4_e),
        .Rd_E        (rd_e),
        .RegWrite_E  (rw_e),
        .MemRead_E   (mr_e),
        .MemWrite_E  (mw_e),
        .ResultSrc_E (rs_e),
        .Funct3_E    (f3_e),
        .ALUResult_M (alu_m),
        .Rd_M        (rd_m),
        .RegWrite_M  (rw_m),
        .Stall_M     (stall_m),
        .dmem        (dmem_bus),
        .Result_W    (result_w),
        .Rd_W        (rd_w),
        .RegWrite_W  (rw_w),
`ifdef MISALIGN_TRAP_EN
        .Misaligned_W(mis_w),
`endif
        .BusErr_W    (buserr_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    instr_t      cur;
    int          wait_cnt;
    logic        exp_rw, exp_be, exp_mis, exp_chk;
    logic [63:0] exp_res;
    logic [4:0]  exp_rd;
    instr_t      dirq[$];
    logic [63:0] mem [logic [63:0]];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
        return mem[a];
    endfunction

    // Load result from the doubleword: pick size bytes from off, then extend
    function automatic logic [63:0] load_val(input logic [63:0] dw, input logic [2:0] off, input logic [2:0] f3);
        logic [63:0] v;
        int size;
        v = 64'h0;
        size = 1 << f3[1:0];
        if (f3 == 3'b111) return 64'h0;
        for (int i = 0; i < size; i++)
            if (int'(off) + i < 8) v[8*i +: 8] = dw[8*(int'(off) + i) +: 8];
        if (!f3[2] && size < 8 && v[8*size-1])
            for (int b = 8*size; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic instr_t mk(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                                  input logic mr, input logic mw, input logic [2:0] f3,
                                  input logic [1:0] rs, input logic rw, input logic [7:0] lat);
        instr_t i;
        i = '0;
        i.alu = alu; i.wd = wd; i.pc4 = 64'h4000; i.rd = rd; i.mr = mr; i.mw = mw;
        i.f3 = f3; i.rs = rs; i.rw = rw; i.lat = lat;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int k;
        i = '0;
        k = $urandom_range(0, 2);
        i.wd  = {$urandom, $urandom};
        i.pc4 = {$urandom, $urandom};
        i.rd  = 5'($urandom);
        i.f3  = 3'($urandom_range(0, 7));
        i.lat = ($urandom_range(0, 39) == 0) ? 8'd200 : 8'($urandom_range(0, 4));
        case (k)
            0: begin
                i.alu = {$urandom, $urandom};
                i.rw  = 1'($urandom_range(0, 1));
                i.rs  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            end
            1: begin
                i.alu = 64'h1000 + 64'($urandom_range(0, 63));
                i.mr = 1'b1; i.rw = 1'b1; i.rs = 2'b01;
            end
            default: begin
                i.alu = 64'h1000 + 64'($urandom_range(0, 63));
                i.mw = 1'b1;
                i.f3 = 3'($urandom_range(0, 3));
            end
        endcase
        return i;
    endfunction

    task automatic drive_e(input instr_t i);
        alu_e = i.alu; wd_e = i.wd; pc4_e = i.pc4; rd_e = i.rd; rw_e = i.rw;
        mr_e = i.mr; mw_e = i.mw; rs_e = i.rs; f3_e = i.f3;
    endtask

    task automatic expect_zero_wb();
        cur = '0; wait_cnt = 0;
        exp_rw = 1'b0; exp_be = 1'b0; exp_mis = 1'b0; exp_chk = 1'b1;
        exp_res = 64'h0; exp_rd = 5'd0;
    endtask

    task automatic check_reset_zero(input string where);
        check_eq({where, "_alu_m"},   alu_m, 64'h0);
        check_eq({where, "_rd_m"},    64'(rd_m), 64'h0);
        check_eq({where, "_rw_m"},    64'(rw_m), 64'h0);
        check_eq({where, "_stall"},   64'(stall_m), 64'h0);
        check_eq({where, "_req"},     64'(dmem_bus.DMemReq), 64'h0);
        check_eq({where, "_we"},      64'(dmem_bus.DMemWe), 64'h0);
        check_eq({where, "_addr"},    dmem_bus.DMemAddr, 64'h0);
        check_eq({where, "_wdata"},   dmem_bus.DMemWData, 64'h0);
        check_eq({where, "_be"},      64'(dmem_bus.DMemBe), 64'h0);
        check_eq({where, "_result"},  result_w, 64'h0);
        check_eq({where, "_rd_w"},    64'(rd_w), 64'h0);
        check_eq({where, "_rw_w"},    64'(rw_w), 64'h0);
        check_eq({where, "_buserr"},  64'(buserr_w), 64'h0);
`ifdef MISALIGN_TRAP_EN
        check_eq({where, "_mis"},     64'(mis_w), 64'h0);
`endif
    endtask

    // One pipeline cycle: check outputs, act as memory, predict the next state
    task automatic step();
        logic [2:0]  off;
        logic [63:0] dwa, dw, ewd, res;
        logic [7:0]  ebe;
        int          size;
        logic        req, ack, tmo, stl, mis;
        instr_t      nxt;
        @(negedge clk);
        check_eq("regwrite_w", 64'(rw_w), 64'(exp_rw));
        check_eq("buserr_w", 64'(buserr_w), 64'(exp_be));
`ifdef MISALIGN_TRAP_EN
        check_eq("misaligned_w", 64'(mis_w), 64'(exp_mis));
`endif
        if (exp_chk) begin
            check_eq("result_w", result_w, exp_res);
            check_eq("rd_w", 64'(rd_w), 64'(exp_rd));
        end
        check_eq("aluresult_m", alu_m, cur.alu);
        check_eq("rd_m", 64'(rd_m), 64'(cur.rd));
        check_eq("regwrite_m", 64'(rw_m), 64'(cur.rw));

        off  = cur.alu[2:0];
        dwa  = {cur.alu[63:3], 3'b000};
        size = 1 << cur.f3[1:0];
        mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((cur.mr || cur.mw) && (int'(off) % size) != 0) mis = 1'b1;
`endif
        req = (cur.mr || cur.mw) && !mis;
        dw  = {$urandom, $urandom};
        if (req) begin
            ack = (wait_cnt == int'(cur.lat));
            if (ack) dw = mem_rd(dwa);
        end else begin
            ack = ($urandom_range(0, 7) == 0);
        end
        dmem_bus.DMemAck   = ack;
        dmem_bus.DMemRData = dw;
        #1;
        check_eq("dmem_req", 64'(dmem_bus.DMemReq), 64'(req));
        ewd = cur.wd << (8 * int'(off));
        ebe = 8'h00;
        for (int i = 0; i < size; i++)
            if (int'(off) + i < 8) ebe[int'(off) + i] = 1'b1;
        if (req) begin
            check_eq("dmem_addr", dmem_bus.DMemAddr, dwa);
            check_eq("dmem_we", 64'(dmem_bus.DMemWe), 64'(cur.mw));
            if (cur.mw) begin
                check_eq("dmem_be", 64'(dmem_bus.DMemBe), 64'(ebe));
                check_eq("dmem_wdata", dmem_bus.DMemWData, ewd);
            end
        end
        tmo = req && !ack && (wait_cnt + 1 == TMO);
        stl = req && !ack && !tmo;
        check_eq("stall_m", 64'(stall_m), 64'(stl));

        if (stl) begin
            wait_cnt++;
            exp_rw = 1'b0; exp_be = 1'b0; exp_mis = 1'b0; exp_chk = 1'b0;
        end else begin
            wait_cnt = 0;
            exp_be  = tmo;
            exp_mis = mis;
            exp_rw  = cur.rw && !tmo && !mis;
            exp_chk = !tmo && !mis;
            exp_rd  = cur.rd;
            case (cur.rs)
                2'b00:   res = cur.alu;
                2'b01:   res = load_val(dw, off, cur.f3);
                2'b10:   res = cur.pc4;
                default: res = 64'h0;
            endcase
            exp_res = res;
            if (req && ack && cur.mw) begin
                dw = mem_rd(dwa);
                for (int b = 0; b < 8; b++)
                    if (ebe[b]) dw[8*b +: 8] = ewd[8*b +: 8];
                mem[dwa] = dw;
            end
        end
        if (!stl && dirq.size() > 0) nxt = dirq.pop_front();
        else nxt = rand_instr();
        drive_e(nxt);
        if (!stl) cur = nxt;
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        drive_e('0);
        dmem_bus.DMemAck   = 1'b0;
        dmem_bus.DMemRData = 64'h0;
        mem[64'h200] = 64'h0000000080000000;

        dirq.push_back(mk(64'h100, 64'h1122334455667788, 5'd0, 1'b0, 1'b1, 3'b011, 2'b00, 1'b0, 8'd3));
        dirq.push_back(mk(64'h203, 64'h0, 5'd5, 1'b1, 1'b0, 3'b000, 2'b01, 1'b1, 8'd1));
        dirq.push_back(mk(64'h203, 64'h0, 5'd6, 1'b1, 1'b0, 3'b100, 2'b01, 1'b1, 8'd0));
        dirq.push_back(mk(64'h106, 64'hBEEF, 5'd0, 1'b0, 1'b1, 3'b001, 2'b00, 1'b0, 8'd0));
        dirq.push_back(mk(64'h208, 64'h0, 5'd8, 1'b1, 1'b0, 3'b010, 2'b01, 1'b1, 8'd0));
        dirq.push_back(mk(64'h42, 64'h0, 5'd9, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 8'd0));
        dirq.push_back(mk(64'h108, 64'h0, 5'd10, 1'b1, 1'b0, 3'b011, 2'b01, 1'b1, 8'd200));
`ifdef MISALIGN_TRAP_EN
        dirq.push_back(mk(64'h102, 64'h0, 5'd11, 1'b1, 1'b0, 3'b010, 2'b01, 1'b1, 8'd0));
`endif

        // Reset with random inputs and spurious acks on the bus
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_reset_zero("reset");
            drive_e(rand_instr());
            dmem_bus.DMemAck = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_reset_zero("reset");
        rst = 1'b0;
        drive_e('0);
        dmem_bus.DMemAck = 1'b0;
        expect_zero_wb();

        repeat (260) step();

        // Reset in the middle of an access, followed by a late ack
        dirq.push_back(mk(64'h1008, 64'h0, 5'd12, 1'b1, 1'b0, 3'b011, 2'b01, 1'b1, 8'd200));
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            step();
            if (cur.mr && cur.lat == 8'd200 && wait_cnt >= 2) found = 1'b1;
        end
        check_eq("rst_setup_reached", 64'(found), 64'h1);
        @(negedge clk);
        check_eq("req_before_rst", 64'(dmem_bus.DMemReq), 64'(found));
        rst = 1'b1;
        dmem_bus.DMemAck = 1'b0;
        drive_e('0);
        @(negedge clk);
        check_reset_zero("rst_mid");
        rst = 1'b0;
        dmem_bus.DMemAck   = 1'b1;
        dmem_bus.DMemRData = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check_eq("late_ack_req", 64'(dmem_bus.DMemReq), 64'h0);
        check_eq("late_ack_stall", 64'(stall_m), 64'h0);
        @(negedge clk);
        check_reset_zero("late_ack");
        dmem_bus.DMemAck = 1'b0;
        expect_zero_wb();
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
